sd_block_arbiter: RTL and testbench

SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

---
 rtl/sd_block_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_sd_block_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_arbiter.sv
// -----------------------------------------------------------------------------
// sd_block_arbiter
//
// Shares a single SD host channel between two drive front-ends (drive 0 and
// drive 1). A pending drive is granted in IDLE; its sector address and
// operation are latched and presented to the host as a per-drive request bit.
// The host raises sd_ack while it moves the sector, and drops it to finish.
// The granted drive then gets a one-cycle done pulse. On contention the 1-bit
// priority register decides, and it always rotates to the drive that was not
// just served.
//
// Sequence: IDLE -> REQ -> XFER -> DONE -> IDLE
//
// Optional build macro:
//   SD_ARB_TIMEOUT_EN  adds a 24-bit watchdog. It clears on grant and counts
//                      every REQ/XFER cycle. When it reaches TIMEOUT_CYCLES the
//                      transfer is forced to DONE, and reqN_err pulses in place
//                      of reqN_done. Without the macro, reqN_err is tied low
//                      and REQ/XFER wait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in clk_sys cycles (used only with the macro)
//
// Ports:
//   clk_sys              system clock, rising edge
//   reset_n              asynchronous active-low reset
//   reqN_lba[31:0]       sector address from drive N
//   reqN_rd / reqN_wr    level read/write request from drive N, held until done
//   reqN_din[7:0]        write data from drive N's sector buffer
//   reqN_buff_wr         buffer write strobe routed to drive N
//   reqN_done            one-cycle completion pulse to drive N
//   reqN_err             one-cycle watchdog-abort pulse to drive N
//   sd_lba[31:0]         latched sector address to the SD host
//   sd_rd[1:0]/sd_wr[1:0] per-drive request to the host, bit = granted drive
//   sd_ack               host transfer-active acknowledge
//   sd_buff_wr           host buffer write strobe
//   sd_buff_din[7:0]     write data muxed from the granted drive
//   busy                 high whenever not IDLE
// -----------------------------------------------------------------------------
module sd_block_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic [31:0] req0_lba,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [7:0]  req0_din,
  output logic        req0_buff_wr,
  output logic        req0_done,
  output logic        req0_err,

  input  logic [31:0] req1_lba,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [7:0]  req1_din,
  output logic        req1_buff_wr,
  output logic        req1_done,
  output logic        req1_err,

  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic pend0;
  logic pend1;
  logic any_pend;
  logic pick;
  logic grant;
  logic prio;
  logic op_rd;
  logic timeout_hit;
  logic abort;

  assign pend0    = req0_rd | req0_wr;
  assign pend1    = req1_rd | req1_wr;
  assign any_pend = pend0 | pend1;
  // A lone requester wins outright; contention defers to the priority bit.
  assign pick     = (pend0 & pend1) ? prio : pend1;

  // State register. The request outputs are decoded from it, so an
  // asynchronous reset drops sd_rd/sd_wr in the same cycle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant bookkeeping: latched only when IDLE accepts a request, so the
  // transfer continues even if the drive lets its request go mid-flight.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      grant  <= 1'b0;
      prio   <= 1'b0;
      op_rd  <= 1'b0;
      sd_lba <= '0;
    end else begin
      if (state == ST_IDLE && any_pend) begin
        grant  <= pick;
        sd_lba <= pick ? req1_lba : req0_lba;
        op_rd  <= pick ? req1_rd  : req0_rd;
      end
      if (state == ST_DONE) begin
        prio <= ~grant;
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] wd_cnt;
  logic        in_wait;

  assign in_wait = (state == ST_REQ) || (state == ST_XFER);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ST_IDLE && any_pend) begin
      wd_cnt <= '0;
    end else if (in_wait) begin
      wd_cnt <= wd_cnt + 24'd1;
    end
  end

  // Fires on the cycle whose closing edge would make the count reach the
  // limit, so DONE lands exactly TIMEOUT_CYCLES cycles after the grant.
  assign timeout_hit = in_wait &&
                       (({1'b0, wd_cnt} + 25'd1) >= {1'b0, TIMEOUT_CYCLES});

  // timeout_hit is only ever high on the cycle that leads into DONE, so its
  // registered copy marks that DONE visit as an abort.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      abort <= 1'b0;
    end else begin
      abort <= timeout_hit;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign abort          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nxt    = state;
    sd_rd        = '0;
    sd_wr        = '0;
    req0_buff_wr = 1'b0;
    req1_buff_wr = 1'b0;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    req0_err     = 1'b0;
    req1_err     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (any_pend) begin
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        if (op_rd) begin
          sd_rd[grant] = 1'b1;
        end else begin
          sd_wr[grant] = 1'b1;
        end
        // A stale-high sd_ack still leaves the request up for one cycle.
        if (timeout_hit) begin
          state_nxt = ST_DONE;
        end else if (sd_ack) begin
          state_nxt = ST_XFER;
        end
      end

      ST_XFER: begin
        req0_buff_wr = sd_buff_wr & ~grant;
        req1_buff_wr = sd_buff_wr &  grant;
        if (timeout_hit || !sd_ack) begin
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        req0_done = ~grant & ~abort;
        req1_done =  grant & ~abort;
        req0_err  = ~grant &  abort;
        req1_err  =  grant &  abort;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy        = (state != ST_IDLE);
  assign sd_buff_din = grant ? req1_din : req0_din;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_block_arbiter
//
// Directed scenarios with literal expectations, followed by randomized drive
// and host traffic. A transaction-level model tracks what the arbiter owes the
// drives and the host, and every falling edge compares all DUT outputs against
// it.
// -----------------------------------------------------------------------------
module tb_sd_block_arbiter;

  localparam logic [23:0] TO = 24'd100;
  // The 100-cycle watchdog would cut a 512-strobe transfer short.
`ifdef SD_ARB_TIMEOUT_EN
  localparam int NPULSE = 40;
`else
  localparam int NPULSE = 512;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  rq_rd   = '0;
  logic [1:0]  rq_wr   = '0;
  logic [31:0] rq_lba [2] = '{32'd0, 32'd0};
  logic [7:0]  rq_din [2] = '{8'hA5, 8'h3C};
  logic        sd_ack     = 1'b0;
  logic        sd_buff_wr = 1'b0;

  logic        req0_buff_wr, req1_buff_wr;
  logic        req0_done, req1_done, req0_err, req1_err;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic [7:0]  sd_buff_din;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int bw0_cnt  = 0;
  int bw1_cnt  = 0;

  sd_block_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .req0_lba    (rq_lba[0]),
    .req0_rd     (rq_rd[0]),
    .req0_wr     (rq_wr[0]),
    .req0_din    (rq_din[0]),
    .req0_buff_wr(req0_buff_wr),
    .req0_done   (req0_done),
    .req0_err    (req0_err),
    .req1_lba    (rq_lba[1]),
    .req1_rd     (rq_rd[1]),
    .req1_wr     (rq_wr[1]),
    .req1_din    (rq_din[1]),
    .req1_buff_wr(req1_buff_wr),
    .req1_done   (req1_done),
    .req1_err    (req1_err),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // m_ph: 0 no transaction, 1 request shown to host, 2 host moving data,
  //       3 completion being reported
  int          m_ph    = 0;
  int          m_cnt   = 0;
  logic        m_g     = 1'b0;
  logic        m_prio  = 1'b0;
  logic        m_rd    = 1'b0;
  logic        m_abort = 1'b0;
  logic [31:0] m_lba   = '0;
  logic [1:0]  m_fin   = '0;
  logic        pend0, pend1, pick;

  assign pend0 = rq_rd[0] | rq_wr[0];
  assign pend1 = rq_rd[1] | rq_wr[1];
  assign pick  = (pend0 && pend1) ? m_prio : pend1;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0; m_cnt <= 0; m_g <= 1'b0; m_prio <= 1'b0;
      m_rd <= 1'b0; m_abort <= 1'b0; m_lba <= '0; m_fin <= '0;
    end else begin
      m_fin <= '0;
      case (m_ph)
        0: if (pend0 || pend1) begin
          m_ph  <= 1;
          m_g   <= pick;
          m_lba <= pick ? rq_lba[1] : rq_lba[0];
          m_rd  <= pick ? rq_rd[1]  : rq_rd[0];
          m_cnt <= 0;
        end
        1, 2: begin
          m_cnt <= m_cnt + 1;
`ifdef SD_ARB_TIMEOUT_EN
          if (m_cnt + 1 >= int'(TO)) begin
            m_ph <= 3; m_abort <= 1'b1;
          end else
`endif
          if (m_ph == 1 && sd_ack)       m_ph <= 2;
          else if (m_ph == 2 && !sd_ack) m_ph <= 3;
        end
        default: begin
          m_ph       <= 0;
          m_abort    <= 1'b0;
          m_prio     <= ~m_g;
          m_fin[m_g] <= 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk_sys) begin
    chk("busy",        32'(busy),        32'(m_ph != 0));
    chk("sd_lba",      sd_lba,           m_lba);
    chk("sd_rd",       32'(sd_rd),       (m_ph == 1 &&  m_rd) ? (32'd1 << m_g) : 32'd0);
    chk("sd_wr",       32'(sd_wr),       (m_ph == 1 && !m_rd) ? (32'd1 << m_g) : 32'd0);
    chk("sd_buff_din", 32'(sd_buff_din), 32'(m_g ? rq_din[1] : rq_din[0]));
    chk("buff_wr0",    32'(req0_buff_wr), 32'(m_ph == 2 && !m_g && sd_buff_wr));
    chk("buff_wr1",    32'(req1_buff_wr), 32'(m_ph == 2 &&  m_g && sd_buff_wr));
    chk("done0",       32'(req0_done),   32'(m_ph == 3 && !m_g && !m_abort));
    chk("done1",       32'(req1_done),   32'(m_ph == 3 &&  m_g && !m_abort));
    chk("err0",        32'(req0_err),    32'(m_ph == 3 && !m_g &&  m_abort));
    chk("err1",        32'(req1_err),    32'(m_ph == 3 &&  m_g &&  m_abort));
    if (req0_buff_wr) bw0_cnt++;
    if (req1_buff_wr) bw1_cnt++;
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Entered just after an edge with the arbiter in REQ; leaves just after the
  // edge that moves it into DONE.
  task automatic host_xfer(input int p);
    sd_ack = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("xfer_req_low", 32'(sd_rd | sd_wr), 32'd0);
    chk("xfer_busy", 32'(busy), 32'd1);
    tick();
    repeat (p) begin
      sd_buff_wr = 1'b1; tick();
      sd_buff_wr = 1'b0; tick();
    end
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic finish_done(input int n);
    @(negedge clk_sys);
    chk("done_pulse", 32'(n ? req1_done : req0_done), 32'd1);
    chk("done_other", 32'(n ? req0_done : req1_done), 32'd0);
    tick();
    rq_rd[n] = 1'b0;
    rq_wr[n] = 1'b0;
    @(negedge clk_sys);
    chk("done_single", 32'(n ? req1_done : req0_done), 32'd0);
  endtask

  initial begin
    logic [1:0] op;
    int hs;
    int hlen;
    hs = 0;
    hlen = 0;

    #1 reset_n = 1'b0;
    @(negedge clk_sys);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_sd_rd", 32'(sd_rd),       32'd0);
    chk("rst_sd_wr", 32'(sd_wr),       32'd0);
    chk("rst_lba",   sd_lba,           32'd0);
    chk("rst_din",   32'(sd_buff_din), 32'h0000_00A5);
    tick();
    reset_n = 1'b1;
    tick();

    // Single read from drive 0.
    rq_lba[0] = 32'h12; rq_rd[0] = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("r1_lba",   sd_lba,     32'h12);
    chk("r1_sd_rd", 32'(sd_rd), 32'd1);
    chk("r1_sd_wr", 32'(sd_wr), 32'd0);
    repeat (2) begin
      tick();
      @(negedge clk_sys);
      chk("r1_rd_hold", 32'(sd_rd), 32'd1);
    end
    tick();
    host_xfer(0);
    finish_done(0);
    tick();

    // Reset in the middle of a transfer.
    rq_lba[0] = 32'hCAFE; rq_rd[0] = 1'b1;
    tick();
    sd_ack = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("rx_sd_rd", 32'(sd_rd), 32'd0);
    chk("rx_busy",  32'(busy),  32'd0);
    chk("rx_lba",   sd_lba,     32'd0);
    rq_rd[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    sd_ack = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      chk("rx_no_done", 32'(req0_done), 32'd0);
      chk("rx_idle",    32'(busy),      32'd0);
      tick();
    end

    // Contention right after reset, then the priority rotation.
    rq_lba[0] = 32'h100; rq_rd[0] = 1'b1;
    rq_lba[1] = 32'h200; rq_wr[1] = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("c1_sd_rd", 32'(sd_rd), 32'h1);
    chk("c1_sd_wr", 32'(sd_wr), 32'h0);
    chk("c1_lba",   sd_lba,     32'h100);
    tick();
    host_xfer(2);
    finish_done(0);
    tick();
    @(negedge clk_sys);
    chk("c2_sd_wr", 32'(sd_wr), 32'h2);
    chk("c2_sd_rd", 32'(sd_rd), 32'h0);
    chk("c2_lba",   sd_lba,     32'h200);
    bw0_cnt = 0;
    bw1_cnt = 0;
    tick();
    sd_buff_wr = 1'b1;
    tick();
    sd_buff_wr = 1'b0;
    host_xfer(NPULSE);
    finish_done(1);
    chk("bw1_count", 32'(bw1_cnt), 32'(NPULSE));
    chk("bw0_count", 32'(bw0_cnt), 32'd0);
    tick();
    rq_lba[0] = 32'h300; rq_wr[0] = 1'b1;
    rq_lba[1] = 32'h400; rq_rd[1] = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("c3_sd_wr", 32'(sd_wr), 32'h1);
    chk("c3_sd_rd", 32'(sd_rd), 32'h0);
    tick();
    host_xfer(1);
    finish_done(0);
    tick();
    @(negedge clk_sys);
    chk("c4_sd_rd", 32'(sd_rd), 32'h2);
    chk("c4_lba",   sd_lba,     32'h400);
    tick();
    host_xfer(0);
    finish_done(1);
    tick();

    // Read and write raised together: read wins.
    rq_lba[0] = 32'h36; rq_rd[0] = 1'b1; rq_wr[0] = 1'b1;
    tick();
    @(negedge clk_sys);
    chk("rw_sd_rd", 32'(sd_rd), 32'h1);
    chk("rw_sd_wr", 32'(sd_wr), 32'h0);
    tick();
    host_xfer(0);
    finish_done(0);
    tick();

`ifdef SD_ARB_TIMEOUT_EN
    // Host never acknowledges: watchdog abort 100 cycles after the grant.
    rq_lba[0] = 32'h55; rq_rd[0] = 1'b1;
    tick();
    repeat (99) tick();
    @(negedge clk_sys);
    chk("to_err_early", 32'(req0_err), 32'd0);
    chk("to_busy",      32'(busy),     32'd1);
    tick();
    @(negedge clk_sys);
    chk("to_err",     32'(req0_err),  32'd1);
    chk("to_no_done", 32'(req0_done), 32'd0);
    chk("to_sd_rd",   32'(sd_rd),     32'd0);
    tick();
    rq_rd[0] = 1'b0;
    @(negedge clk_sys);
    chk("to_idle", 32'(busy), 32'd0);
    tick();
`endif

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < 2; n++) begin
        rq_din[n] = 8'($urandom);
        if (m_fin[n]) begin
          rq_rd[n] = 1'b0;
          rq_wr[n] = 1'b0;
        end else if (!(rq_rd[n] | rq_wr[n])) begin
          rq_lba[n] = $urandom;
          if ($urandom_range(0, 3) == 0) begin
            op = 2'($urandom_range(1, 3));
            rq_rd[n] = op[0];
            rq_wr[n] = op[1];
          end
        end
      end
      if (hs == 0) begin
        if (m_ph == 1 && $urandom_range(0, 2) == 0) begin
          sd_ack = 1'b1;
          hlen   = int'($urandom_range(1, 8));
          hs     = 1;
        end else begin
          sd_ack = (m_ph == 0) && ($urandom_range(0, 15) == 0);
        end
      end else begin
        hlen--;
        if (hlen == 0) begin
          sd_ack = 1'b0;
          hs     = 0;
        end
      end
      sd_buff_wr = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
